// File: rtl/mc_control_fsm.sv
// Multicycle RV32I control unit: Moore-style state register plus per-state strobe decode.
// Optional feature macro: ILLEGAL_TRAP_EN (illegal decode traps into HALT and raises Illegal).
module mc_control_fsm (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] Instr,
    input  logic        Zero,
    input  logic        CarryOut,
    input  logic        Overflow,
    input  logic        Sign,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ImmSrc,
    output logic [3:0]  ALUControl,
    output logic        Illegal
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR1,
        S_JALR2,
        S_LUI,
        S_AUIPC
`ifdef ILLEGAL_TRAP_EN
        ,
        S_HALT
`endif
    } state_t;

    state_t r_state;

    logic [6:0] w_op;
    logic [2:0] w_funct3;
    logic       w_funct7b5;
    logic       w_legal;
    logic       w_unused_instr;

    assign w_op           = Instr[6:0];
    assign w_funct3       = Instr[14:12];
    assign w_funct7b5     = Instr[30];
    assign w_unused_instr = ^{Instr[31], Instr[29:15], Instr[11:7]};

    // funct7b5 selects sub/sra; for immediates it only matters on the shift-right slot,
    // since bit 30 of an addi immediate is ordinary immediate data.
    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic f7b5,
                                              input logic is_rtype);
        logic [3:0] ctl;
        case (f3)
            3'b000:  ctl = (is_rtype && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  ctl = ALU_SLL;
            3'b010:  ctl = ALU_SLT;
            3'b011:  ctl = ALU_SLTU;
            3'b100:  ctl = ALU_XOR;
            3'b101:  ctl = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  ctl = ALU_OR;
            3'b111:  ctl = ALU_AND;
            default: ctl = ALU_ADD;
        endcase
        return ctl;
    endfunction

    function automatic logic branch_taken(input logic [2:0] f3, input logic z, input logic c,
                                          input logic v, input logic n);
        logic taken;
        case (f3)
            3'b000:  taken = z;
            3'b001:  taken = !z;
            3'b100:  taken = n ^ v;
            3'b101:  taken = !(n ^ v);
            3'b110:  taken = !c;
            3'b111:  taken = c;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

    function automatic logic op_legal(input logic [6:0] op, input logic [2:0] f3);
        logic ok;
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: ok = 1'b1;
            OP_BRANCH: ok = (f3 != 3'b010) && (f3 != 3'b011);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign w_legal = op_legal(w_op, w_funct3);

    // State register and next-state sequencing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:  r_state <= S_DECODE;
                S_DECODE: begin
                    if (!w_legal) begin
`ifdef ILLEGAL_TRAP_EN
                        r_state <= S_HALT;
`else
                        r_state <= S_FETCH;
`endif
                    end else begin
                        case (w_op)
                            OP_LOAD, OP_STORE: r_state <= S_MEMADR;
                            OP_RTYPE:          r_state <= S_EXECR;
                            OP_ITYPE:          r_state <= S_EXECI;
                            OP_BRANCH:         r_state <= S_BRANCH;
                            OP_JAL:            r_state <= S_JAL;
                            OP_JALR:           r_state <= S_JALR1;
                            OP_LUI:            r_state <= S_LUI;
                            OP_AUIPC:          r_state <= S_AUIPC;
                            default:           r_state <= S_FETCH;
                        endcase
                    end
                end
                S_MEMADR:   r_state <= (w_op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  r_state <= S_MEMWB;
                S_MEMWB:    r_state <= S_FETCH;
                S_MEMWRITE: r_state <= S_FETCH;
                S_EXECR:    r_state <= S_ALUWB;
                S_EXECI:    r_state <= S_ALUWB;
                S_ALUWB:    r_state <= S_FETCH;
                S_BRANCH:   r_state <= S_FETCH;
                S_JAL:      r_state <= S_ALUWB;
                S_JALR1:    r_state <= S_JALR2;
                S_JALR2:    r_state <= S_ALUWB;
                S_LUI:      r_state <= S_FETCH;
                S_AUIPC:    r_state <= S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
                S_HALT:     r_state <= S_HALT;
`endif
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    // Strobe decode; reset_n gates everything so a reset mid-instruction drops all writes at once.
    always_comb begin
        PCWrite    = 1'b0;
        AdrSrc     = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ImmSrc     = IMM_I;
        ALUControl = ALU_ADD;
        Illegal    = 1'b0;
        if (reset_n) begin
            case (r_state)
                S_FETCH: begin
                    IRWrite   = 1'b1;
                    PCWrite   = 1'b1;
                    ALUSrcB   = 2'b10;
                    ResultSrc = 2'b10;
                end
                S_DECODE: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                    ImmSrc  = (w_op == OP_JAL) ? IMM_J : IMM_B;
                end
                S_MEMADR: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                    ImmSrc  = (w_op == OP_STORE) ? IMM_S : IMM_I;
                end
                S_MEMREAD: begin
                    AdrSrc = 1'b1;
                end
                S_MEMWB: begin
                    ResultSrc = 2'b01;
                    RegWrite  = 1'b1;
                end
                S_MEMWRITE: begin
                    AdrSrc   = 1'b1;
                    MemWrite = 1'b1;
                end
                S_EXECR: begin
                    ALUSrcA    = 2'b10;
                    ALUControl = alu_decode(w_funct3, w_funct7b5, 1'b1);
                end
                S_EXECI: begin
                    ALUSrcA    = 2'b10;
                    ALUSrcB    = 2'b01;
                    ALUControl = alu_decode(w_funct3, w_funct7b5, 1'b0);
                end
                S_ALUWB: begin
                    RegWrite = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA    = 2'b10;
                    ALUControl = ALU_SUB;
                    PCWrite    = branch_taken(w_funct3, Zero, CarryOut, Overflow, Sign);
                end
                S_JAL, S_JALR2: begin
                    PCWrite = 1'b1;
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b10;
                end
                S_JALR1: begin
                    ALUSrcA = 2'b10;
                    ALUSrcB = 2'b01;
                end
                S_LUI: begin
                    ImmSrc    = IMM_U;
                    ResultSrc = 2'b11;
                    RegWrite  = 1'b1;
                end
                S_AUIPC: begin
                    ALUSrcA = 2'b01;
                    ALUSrcB = 2'b01;
                    ImmSrc  = IMM_U;
                end
`ifdef ILLEGAL_TRAP_EN
                S_HALT: begin
                    Illegal = 1'b1;
                end
`endif
                default: begin
                    PCWrite = 1'b0;
                end
            endcase
        end else begin
            PCWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            Illegal  = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: per-cycle expected strobe vectors are queued
// with each instruction and compared at the falling edge of every cycle.
module tb_mc_control_fsm;

    logic        clk;
    logic        reset_n;
    logic [31:0] Instr;
    logic        Zero, CarryOut, Overflow, Sign;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0]  ImmSrc;
    logic [3:0]  ALUControl;
    logic        Illegal;

    mc_control_fsm dut (
        .clk(clk), .reset_n(reset_n), .Instr(Instr),
        .Zero(Zero), .CarryOut(CarryOut), .Overflow(Overflow), .Sign(Sign),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .Illegal(Illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [18:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic [18:0] obs_v;
    assign obs_v = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
                    ALUSrcB, ImmSrc, ALUControl, Illegal};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Vector order: pcw adr mw irw rw | rs sa sb | imm | alu | ill
    task automatic push(input string tag, input logic pcw, input logic adr, input logic mw,
                        input logic irw, input logic rw, input logic [1:0] rs,
                        input logic [1:0] sa, input logic [1:0] sb, input logic [2:0] imm,
                        input logic [3:0] alu, input logic ill);
        exp_t e;
        e.tag = tag;
        e.v   = {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu, ill};
        exp_q.push_back(e);
    endtask

    task automatic p_zero(input string tag, input logic ill);
        push(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, ill);
    endtask

    task automatic p_fetch(input string tag);
        push({tag, ".fetch"}, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 3'b000, 4'b0000, 1'b0);
    endtask

    task automatic p_decode(input string tag, input logic [2:0] imm);
        push({tag, ".decode"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, imm, 4'b0000, 1'b0);
    endtask

    task automatic p_aluwb(input string tag);
        push({tag, ".aluwb"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0);
    endtask

    // One comparison per clock cycle until every queued expectation is consumed.
    task automatic drain();
        exp_t e;
        while (exp_q.size() != 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            check_eq(e.tag, {13'd0, obs_v}, {13'd0, e.v});
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_in(input logic [31:0] ins, input logic z, input logic c,
                          input logic v, input logic n);
        Instr    = ins;
        Zero     = z;
        CarryOut = c;
        Overflow = v;
        Sign     = n;
    endtask

    task automatic do_rtype(input string tag, input logic [31:0] ins, input logic [3:0] alu);
        set_in(ins, 1'b0, 1'b0, 1'b0, 1'b0);
        p_fetch(tag);
        p_decode(tag, 3'b010);
        push({tag, ".exec"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b000, alu, 1'b0);
        p_aluwb(tag);
        drain();
    endtask

    task automatic do_itype(input string tag, input logic [31:0] ins, input logic [3:0] alu);
        set_in(ins, 1'b0, 1'b0, 1'b0, 1'b0);
        p_fetch(tag);
        p_decode(tag, 3'b010);
        push({tag, ".exec"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, alu, 1'b0);
        p_aluwb(tag);
        drain();
    endtask

    task automatic do_branch(input string tag, input logic [31:0] ins, input logic z,
                             input logic c, input logic v, input logic n, input logic taken);
        set_in(ins, z, c, v, n);
        p_fetch(tag);
        p_decode(tag, 3'b010);
        push({tag, ".branch"}, taken, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b000, 4'b0001, 1'b0);
        drain();
    endtask

    task automatic do_illegal(input string tag, input logic [31:0] ins);
        set_in(ins, 1'b0, 1'b0, 1'b0, 1'b0);
        p_fetch(tag);
        p_decode(tag, 3'b010);
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 20; i++) p_zero({tag, ".halt"}, 1'b1);
        drain();
        reset_n = 1'b0;
        p_zero({tag, ".reset"}, 1'b0);
        drain();
        reset_n = 1'b1;
`else
        drain();
`endif
    endtask

    initial begin
        reset_n = 1'b0;
        set_in(32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
        p_zero("por", 1'b0);
        drain();
        reset_n = 1'b1;

        // add interrupted by reset in EXECR: strobes drop immediately, no writeback follows.
        set_in(32'h0020_81B3, 1'b0, 1'b0, 1'b0, 1'b0);
        p_fetch("add_rst");
        p_decode("add_rst", 3'b010);
        drain();
        reset_n = 1'b0;
        p_zero("add_rst.midreset", 1'b0);
        drain();
        reset_n = 1'b1;

        do_rtype("add", 32'h0020_81B3, 4'b0000);
        do_rtype("sub", 32'h4020_81B3, 4'b0001);
        do_rtype("sra", 32'h4020_D1B3, 4'b1001);
        do_rtype("sltu", 32'h0020_B1B3, 4'b0110);
        do_itype("srai", 32'h4030_D293, 4'b1001);
        do_itype("addi_neg", 32'hFFF0_8293, 4'b0000);
        do_itype("ori", 32'h0FF0_E293, 4'b0011);

        set_in(32'h0080_A283, 1'b0, 1'b0, 1'b0, 1'b0);
        p_fetch("lw");
        p_decode("lw", 3'b010);
        push("lw.memadr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 4'b0000, 1'b0);
        push("lw.memread", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0);
        push("lw.memwb", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0);
        drain();

        set_in(32'h0050_A623, 1'b0, 1'b0, 1'b0, 1'b0);
        p_fetch("sw");
        p_decode("sw", 3'b010);
        push("sw.memadr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b001, 4'b0000, 1'b0);
        push("sw.memwrite", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 4'b0000, 1'b0);
        drain();

        //                     Instr         Z     C     V     N     taken
        do_branch("beq_t",  32'h0020_8463, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        do_branch("beq_nt", 32'h0020_8463, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        do_branch("bne_nt", 32'h0020_9463, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        do_branch("bltu_t", 32'h0020_E463, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        do_branch("bgeu_nt",32'h0020_F463, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_branch("bge_t",  32'h0020_D463, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        do_branch("blt_t",  32'h0020_C463, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        do_branch("blt_nt", 32'h0020_C463, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        set_in(32'h0001_00E7, 1'b0, 1'b0, 1'b0, 1'b0);
        p_fetch("jalr");
        p_decode("jalr", 3'b010);
        push("jalr.1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 4'b0000, 1'b0);
        push("jalr.2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000, 4'b0000, 1'b0);
        p_aluwb("jalr");
        drain();

        set_in(32'h0100_00EF, 1'b0, 1'b0, 1'b0, 1'b0);
        p_fetch("jal");
        p_decode("jal", 3'b011);
        push("jal.jal", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000, 4'b0000, 1'b0);
        p_aluwb("jal");
        drain();

        set_in(32'h1234_52B7, 1'b0, 1'b0, 1'b0, 1'b0);
        p_fetch("lui");
        p_decode("lui", 3'b010);
        push("lui.lui", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 2'b00, 2'b00, 3'b100, 4'b0000, 1'b0);
        drain();

        set_in(32'h0000_1297, 1'b0, 1'b0, 1'b0, 1'b0);
        p_fetch("auipc");
        p_decode("auipc", 3'b010);
        push("auipc.exec", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b100, 4'b0000, 1'b0);
        p_aluwb("auipc");
        drain();

        do_illegal("bad_op", 32'h0000_007F);
        do_illegal("bad_br", 32'h0020_A463);

        p_fetch("final");
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
